// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyph patterns {g,f,e,d,c,b,a}.
// A segment is lit when its bit is 0, so SEG_BLANK (all ones) turns every segment off.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [3:0] NIB_ZERO = 4'h0;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble -> active-low segment lookup.
// Define SEG7_HEX_EN to render 10-15 as A,b,C,d,E,F; otherwise they show blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
`ifdef SEG7_HEX_EN
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
`else
      default: glyph = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow register, round-robin scan with dead time,
// optional leading-zero blanking. Hex glyphs for 10-15 are enabled by defining SEG7_HEX_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [6:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   an_reg;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_run;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_glyph;
  logic                    in_dead;
  logic                    lz_hide;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = shadow_reg[4*gi +: 4];
  end

  // zero_run[i] is set when every nibble from i up to the most significant digit is zero.
  always_comb begin
    logic acc;
    acc      = 1'b1;
    zero_run = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc         = acc && (nib[i] == NIB_ZERO);
      zero_run[i] = acc;
    end
  end

  assign cur_nib = nib[idx_reg];

  seg7_glyph u_glyph (
    .digit (cur_nib),
    .glyph (cur_glyph)
  );

  assign in_dead = (cnt_reg < CNT_DEAD);
  assign lz_hide = lz_blank && (idx_reg != '0) && zero_run[idx_reg];

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = '1;
    if (!in_dead && !lz_hide) begin
      seg_next = cur_glyph;
      an_next  = ~(NUM_DIGITS'(1) << idx_reg);
    end
  end

  // Outputs are computed from the current state and registered, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      seg_reg    <= SEG_BLANK;
      an_reg     <= '1;
    end else begin
      if (load) begin
        shadow_reg <= value;
      end
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule
